// File: rtl/p_node_frame.sv
// Sequential polar P-node leaf decoder: one LLR pair per accept, exact ML
// decision, NUM_PAIR decisions packed into a frame. Optional psum output: PNODE_PSUM_EN.
module p_node_frame #(
  parameter int LLR_W    = 17,
  parameter int NUM_PAIR = 4,
  parameter int CNT_W    = $clog2(NUM_PAIR) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LLR_W-1:0]        llr_1,
  input  logic [LLR_W-1:0]        llr_2,
  input  logic                    frozen_1,
  input  logic                    frozen_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*NUM_PAIR-1:0]   u_hat,
  output logic [CNT_W-1:0]        pair_cnt
`ifdef PNODE_PSUM_EN
  ,
  output logic [2*NUM_PAIR-1:0]   psum
`endif
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_PAIR - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        pair_cnt_q, pair_cnt_d;
  logic [2*NUM_PAIR-1:0]   u_hat_q, u_hat_d, u_hat_wr;

  // Sum is one bit wider than the LLRs so the most-negative pair cannot wrap.
  logic [LLR_W:0]          sum;
  logic                    sum_unused;
  logic                    s1, s2, s_sum;
  logic                    u1, u2;
  logic                    first_accept;

  assign sum        = {llr_1[LLR_W-1], llr_1} + {llr_2[LLR_W-1], llr_2};
  assign sum_unused = ^sum[LLR_W-1:0];
  assign s1         = llr_1[LLR_W-1];
  assign s2         = llr_2[LLR_W-1];
  assign s_sum      = sum[LLR_W];

  always_comb begin
    u1 = 1'b0;
    u2 = 1'b0;
    case ({frozen_1, frozen_2})
      2'b11:   begin u1 = 1'b0;    u2 = 1'b0;  end
      2'b10:   begin u1 = 1'b0;    u2 = s_sum; end
      2'b01:   begin u1 = s1;      u2 = 1'b0;  end
      default: begin u1 = s1 ^ s2; u2 = s2;    end
    endcase
  end

  // The first accept of a frame wipes every slot it does not write.
  assign first_accept = (pair_cnt_q == '0);

`ifdef PNODE_PSUM_EN
  logic [2*NUM_PAIR-1:0]   psum_q, psum_d, psum_wr;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAIR; gi++) begin : g_slot
      assign u_hat_wr[2*gi +: 2] = (pair_cnt_q == CNT_W'(gi)) ? {u2, u1} :
                                   (first_accept ? 2'b00 : u_hat_q[2*gi +: 2]);
`ifdef PNODE_PSUM_EN
      assign psum_wr[2*gi +: 2]  = (pair_cnt_q == CNT_W'(gi)) ? {u2, u1 ^ u2} :
                                   (first_accept ? 2'b00 : psum_q[2*gi +: 2]);
`endif
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    u_hat_d    = u_hat_q;
`ifdef PNODE_PSUM_EN
    psum_d     = psum_q;
`endif
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          u_hat_d    = u_hat_wr;
`ifdef PNODE_PSUM_EN
          psum_d     = psum_wr;
`endif
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
          if (pair_cnt_q == LAST_SLOT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          pair_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      pair_cnt_q <= '0;
      u_hat_q    <= '0;
`ifdef PNODE_PSUM_EN
      psum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      u_hat_q    <= u_hat_d;
`ifdef PNODE_PSUM_EN
      psum_q     <= psum_d;
`endif
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign u_hat     = u_hat_q;
  assign pair_cnt  = pair_cnt_q;
`ifdef PNODE_PSUM_EN
  assign psum      = psum_q;
`endif

endmodule

// File: tb/tb_p_node_frame.sv
// Directed bench for p_node_frame (LLR_W=17, NUM_PAIR=4) with hand-computed frames.
module tb_p_node_frame;

  localparam int LLR_W    = 17;
  localparam int NUM_PAIR = 4;
  localparam int CNT_W    = $clog2(NUM_PAIR) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [LLR_W-1:0]      llr_1;
  logic [LLR_W-1:0]      llr_2;
  logic                  frozen_1;
  logic                  frozen_2;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*NUM_PAIR-1:0] u_hat;
  logic [CNT_W-1:0]      pair_cnt;
`ifdef PNODE_PSUM_EN
  logic [2*NUM_PAIR-1:0] psum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p_node_frame #(.LLR_W(LLR_W), .NUM_PAIR(NUM_PAIR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .llr_1(llr_1), .llr_2(llr_2),
    .frozen_1(frozen_1), .frozen_2(frozen_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .u_hat(u_hat), .pair_cnt(pair_cnt)
`ifdef PNODE_PSUM_EN
    , .psum(psum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input logic f1, input logic f2, input logic v);
    llr_1    = LLR_W'(a);
    llr_2    = LLR_W'(b);
    frozen_1 = f1;
    frozen_2 = f2;
    in_valid = v;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] cnt, input logic ir, input logic ov);
    chk({tag, "_cnt"}, 32'(pair_cnt), cnt);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(-5, 3, 1'b0, 1'b0, 1'b1);

    // Reset held 2 cycles with in_valid high: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_status("reset", 0, 1'b1, 1'b0);
      chk("reset_u_hat", 32'(u_hat), 32'h0);
`ifdef PNODE_PSUM_EN
      chk("reset_psum", 32'(psum), 32'h0);
`endif
    end
    rst_n = 1'b1;

    // Frame 1: unfrozen back-to-back pairs, expected u_hat = 8'b00_10_11_01.
    drive(-5, 3, 1'b0, 1'b0, 1'b1); tick(); chk_status("f1_p0", 1, 1'b1, 1'b0);
    drive(7, -2, 1'b0, 1'b0, 1'b1); tick(); chk_status("f1_p1", 2, 1'b1, 1'b0);
    drive(-4, -9, 1'b0, 1'b0, 1'b1); tick(); chk_status("f1_p2", 3, 1'b1, 1'b0);
    drive(6, 1, 1'b0, 1'b0, 1'b1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk_status("f1_hold", 4, 1'b0, 1'b1);
    chk("f1_u_hat", 32'(u_hat), 32'h2D);
    tick();
    chk_status("f1_release", 0, 1'b1, 1'b0);
    chk("f1_u_hat_kept", 32'(u_hat), 32'h2D);
    $display("frame1 u_hat=%02h", u_hat);

    // Frame 2: frozen combinations; first accept clears stale slots.
    drive(-20, 15, 1'b1, 1'b0, 1'b1); tick();
    chk("f2_first_clear", 32'(u_hat), 32'h02);
    drive(-65536, 65535, 1'b1, 1'b0, 1'b1); tick();
    chk("f2_minneg", 32'(u_hat), 32'h0A);
    drive(0, 0, 1'b0, 1'b0, 1'b0); tick();
    chk_status("f2_gap", 2, 1'b1, 1'b0);
    drive(10, -10, 1'b1, 1'b0, 1'b1); tick();
    out_ready = 1'b0;
    drive(-1, -1, 1'b1, 1'b1, 1'b1); tick();
    chk("f2_u_hat", 32'(u_hat), 32'h0A);
    chk_status("f2_hold", 4, 1'b0, 1'b1);

    // Backpressure: in_valid high for 5 cycles must be ignored.
    drive(-7, -7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_status("bp", 4, 1'b0, 1'b1);
      chk("bp_u_hat", 32'(u_hat), 32'h0A);
    end
    out_ready = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_status("bp_release", 0, 1'b1, 1'b0);
    $display("frame2 u_hat=%02h", u_hat);

    // Reset after 2 of 4 pairs discards the partial frame.
    drive(-5, 3, 1'b0, 1'b0, 1'b1); tick();
    drive(7, -2, 1'b0, 1'b0, 1'b1); tick();
    chk_status("part", 2, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk_status("midrst", 0, 1'b1, 1'b0);
    chk("midrst_u_hat", 32'(u_hat), 32'h0);

    // Frame 3 after reset, expected u_hat = 8'b11_01_00_10.
    drive(-4, -9, 1'b0, 1'b0, 1'b1); tick();
    drive(6, 1, 1'b0, 1'b0, 1'b1); tick();
    drive(-5, 3, 1'b0, 1'b0, 1'b1); tick();
    drive(7, -2, 1'b0, 1'b0, 1'b1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk_status("f3_hold", 4, 1'b0, 1'b1);
    chk("f3_u_hat", 32'(u_hat), 32'hD2);
    tick();
    $display("frame3 u_hat=%02h", u_hat);

    // Frame 4: (-5,3) then (-5,-3) for the partial-sum view.
    drive(-5, 3, 1'b0, 1'b0, 1'b1); tick();
    drive(-5, -3, 1'b0, 1'b0, 1'b1); tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk("f4_u_hat", 32'(u_hat), 32'h09);
`ifdef PNODE_PSUM_EN
    chk("f4_psum", 32'(psum), 32'h0D);
`endif
    $display("frame4 partial u_hat=%02h", u_hat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
